// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
// Shared types for the registered sequential ALU:
//   op_t    - 3-bit opcode encoding (cpy, add, sub, div, mod, shl, shr, cmp)
//   state_t - control FSM states (idle / iterative divide in progress)
//   is_divide() - true for the two opcodes served by the iterative divider
// -----------------------------------------------------------------------------
package seq_alu_pkg;

  typedef enum logic [2:0] {
    OP_CPY = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_CMP = 3'b111
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

  function automatic logic is_divide(input op_t op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_alu_divider.sv
// -----------------------------------------------------------------------------
// alu_divider
// WIDTH-iteration restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start             - load dividend/divisor and begin (ignored while busy)
//   dividend, divisor - unsigned operands; divisor must be non-zero
//   busy              - an iteration is pending on the next clock edge
//   done              - the coming edge performs the final iteration
//   quotient,
//   remainder         - results of the iteration performed on the coming edge;
//                       when done=1 these are the final quotient/remainder, so
//                       the owner can capture them on the same edge.
// -----------------------------------------------------------------------------
module alu_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_q;   // partial remainder
  logic [WIDTH-1:0] quo_q;   // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH+1:0] trial;   // one extra bit so the sign shows whether the subtract fits
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    trial = {1'b0, rem_q, quo_q[WIDTH-1]} - {2'b00, dsr_q};
    if (trial[WIDTH+1]) begin
      // Does not fit: restore, i.e. keep the shifted partial remainder.
      rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
  end

  assign busy      = (count != '0);
  assign done      = (count == CW'(1));
  assign quotient  = quo_d;
  assign remainder = rem_d;

  // NOTE: the datapath registers are reset too, so an aborted divide leaves no stale state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (start && !busy) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      count <= CW'(WIDTH);
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (busy) begin
      count <= count - CW'(1);
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Registered 8-opcode ALU with valid/ready handshakes on both sides.
// Single-cycle ops write the result register on the accept edge; div/mod with
// a non-zero divisor run on alu_divider for WIDTH cycles.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid, in_ready  - operand handshake (in_ready depends on out_ready)
//   in1, in2, select    - operands and opcode (in2[SHW-1:0] is the shift amount)
//   out_valid, out_ready- result handshake
//   out                 - WIDTH+1-bit result
//   dz                  - divide/modulo by zero, qualified by out_valid
// -----------------------------------------------------------------------------
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             dz
);

  localparam logic [SHW-1:0] MAX_AMT = SHW'(WIDTH);

  state_t           state;
  logic             div_is_mod;   // remembers which result to keep while dividing
  op_t              op;
  logic             accept;
  logic             long_div;     // div/mod that needs the iterative divider
  logic             write_result;
  logic [WIDTH:0]   ext1;
  logic [WIDTH:0]   ext2;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   imm_result;
  logic             imm_dz;
  logic [WIDTH:0]   next_out;
  logic             next_dz;

  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  assign op       = op_t'(select);
  assign ext1     = {1'b0, in1};
  assign ext2     = {1'b0, in2};
  assign amt      = in2[SHW-1:0];
  assign in_ready = (state == S_IDLE) && !div_busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign long_div = is_divide(op) && (in2 != '0);

  always_comb begin
    imm_result = '0;
    imm_dz     = 1'b0;
    unique case (op)
      OP_CPY: imm_result = ext1;
      OP_ADD: imm_result = ext1 + ext2;
      OP_SUB: imm_result = ext1 - ext2;
      OP_DIV: begin
        // Only reached with in2 == 0; non-zero divisors go to the divider.
        imm_result = '1;
        imm_dz     = 1'b1;
      end
      OP_MOD: begin
        imm_result = ext1;
        imm_dz     = 1'b1;
      end
      OP_SHL: imm_result = (amt > MAX_AMT) ? '0 : (ext1 << amt);
      OP_SHR: imm_result = (amt > MAX_AMT) ? '0 : (ext1 >> amt);
      OP_CMP: imm_result = {{WIDTH{1'b0}}, (in1 > in2)};
      default: imm_result = '0;
    endcase
  end

  assign write_result = (accept && !long_div) || ((state == S_DIV) && div_done);

  always_comb begin
    next_out = imm_result;
    next_dz  = imm_dz;
    if (state == S_DIV) begin
      next_out = div_is_mod ? {1'b0, div_rem} : {1'b0, div_quo};
      next_dz  = 1'b0;
    end
  end

  alu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (accept && long_div),
    .dividend (in1),
    .divisor  (in2),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      div_is_mod <= 1'b0;
      out_valid  <= 1'b0;
      out        <= '0;
      dz         <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept && long_div) begin
            state      <= S_DIV;
            div_is_mod <= (op == OP_MOD);
          end
        end
        S_DIV: begin
          if (div_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A new result wins over a consume on the same edge, keeping out_valid high.
      if (write_result) begin
        out_valid <= 1'b1;
        out       <= next_out;
        dz        <= next_dz;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Self-checking bench for seq_alu (WIDTH=8): directed scenarios followed by
// randomized operations compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [2:0]   select;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out;
  logic         dz;

  int total = 0;
  int bad   = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .select   (select),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: returns {dz, result}, computed with plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [2:0] sel, input int unsigned a,
                                         input int unsigned b);
    int unsigned r;
    int unsigned amt;
    logic        z;
    logic [W:0]  res;
    z   = 1'b0;
    amt = b % 16;
    case (sel)
      3'd0: r = a;
      3'd1: r = a + b;
      3'd2: r = (a + 512 - b) % 512;
      3'd3: if (b == 0) begin z = 1'b1; r = 511; end else r = a / b;
      3'd4: if (b == 0) begin z = 1'b1; r = a;   end else r = a % b;
      3'd5: r = (amt > W) ? 0 : ((a << amt) % 512);
      3'd6: r = (amt > W) ? 0 : (a >> amt);
      default: r = (a > b) ? 1 : 0;
    endcase
    res = r[W:0];
    return {z, res};
  endfunction

  // Called #1 after a rising edge with out_ready=1. Issues one op, measures the
  // number of edges after the accept edge until out_valid, checks the result,
  // then optionally stalls the consumer for 'stall' cycles.
  task automatic run_op(input string tag, input logic [2:0] sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int stall);
    logic [W+1:0] exp;
    logic         long_op;
    int           n;
    int           lat;
    exp     = model(sel, a, b);
    long_op = (sel == 3'd3 || sel == 3'd4) && (b != 0);
    select  = sel;
    in1     = a;
    in2     = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), long_op ? 32'(W) : 32'd0);
    check({tag, "_out"}, 32'(out), 32'(exp[W:0]));
    check({tag, "_dz"}, 32'(dz), 32'(exp[W+1]));
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_hold_out"}, 32'(out), 32'(exp[W:0]));
        check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   s_tab [4];
    logic [W-1:0] a_tab [4];
    logic [W-1:0] b_tab [4];
    logic [W:0]   e_tab [4];

    rst       = 1'b1;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    select    = 3'd0;
    out_ready = 1'b1;
    #12;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    check("reset_dz", 32'(dz), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of a divide.
    select = 3'd3; in1 = 8'd200; in2 = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("middiv_rst_valid", 32'(out_valid), 32'd0);
    check("middiv_rst_out", 32'(out), 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check("middiv_ready", 32'(in_ready), 32'd1);
    check("middiv_valid", 32'(out_valid), 32'd0);
    run_op("after_rst_cpy", 3'd0, 8'h5A, 8'h00, 0);

    // Four single-cycle ops streamed in four consecutive cycles.
    s_tab = '{3'd1, 3'd2, 3'd7, 3'd7};
    a_tab = '{8'hFF, 8'h03, 8'd9, 8'd3};
    b_tab = '{8'h01, 8'h05, 8'd3, 8'd3};
    e_tab = '{9'h100, 9'h1FE, 9'h001, 9'h000};
    select = s_tab[0]; in1 = a_tab[0]; in2 = b_tab[0]; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stream%0d_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      if (i < 3) begin
        select = s_tab[i+1]; in1 = a_tab[i+1]; in2 = b_tab[i+1];
      end else begin
        in_valid = 1'b0;
      end
      check($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d_out", i), 32'(out), 32'(e_tab[i]));
    end
    @(posedge clk); #1;

    // Divide latency, divide by zero, shifts.
    run_op("div_200_7", 3'd3, 8'd200, 8'd7, 0);
    run_op("mod_200_7", 3'd4, 8'd200, 8'd7, 0);
    run_op("div_by_0", 3'd3, 8'h37, 8'h00, 0);
    run_op("mod_by_0", 3'd4, 8'h37, 8'h00, 0);
    run_op("shl_81_1", 3'd5, 8'h81, 8'd1, 0);
    run_op("shl_81_9", 3'd5, 8'h81, 8'd9, 0);
    run_op("shr_f0_4", 3'd6, 8'hF0, 8'd4, 0);
    run_op("shl_01_8", 3'd5, 8'h01, 8'd8, 0);

    // Backpressure: result held, second op blocked until the consumer frees the slot.
    @(posedge clk); #1;
    out_ready = 1'b0;
    select = 3'd1; in1 = 8'd1; in2 = 8'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    select = 3'd0; in1 = 8'h11; in2 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_out", 32'(out), 32'd3);
      check("bp_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_out", 32'(out), 32'h011);

    // Randomized operations with occasional consumer stalls.
    for (int i = 0; i < 150; i++) begin
      sel = 3'($urandom_range(0, 7));
      a   = 8'($urandom_range(0, 255));
      b   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      if (sel == 3'd5 || sel == 3'd6) b = 8'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d_op%0d", i, sel), sel, a, b, int'($urandom_range(0, 2)));
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the team's 4-bit combinational ALU. It executes the same eight 3-bit opcodes on unsigned WIDTH-bit operands, with valid/ready handshakes on both sides. Divide and modulo run on an iterative restoring divider instead of a combinational one, and shifts take a variable amount from in2. The block sits between an operand-issue stage and a result consumer that may apply backpressure.

## Interface
- WIDTH, 8: operand width (≥2); result is WIDTH+1 bits.
- SHW, $clog2(WIDTH+1): width of the shift-amount field taken from in2[SHW-1:0].

Ports (clock and reset first):
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands/select valid.
- in_ready  out  1  block can accept a new operation.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B or shift amount.
- select  in  3  opcode.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer accepts the result.
- out  out  WIDTH+1  result.
- dz  out  1  divide/modulo by zero occurred; qualified by out_valid.

## Operation
Opcodes: 000 cpy, 001 add, 010 sub, 011 div, 100 mod, 101 shl, 110 shr, 111 cmp.

- An operation is accepted when in_valid && in_ready. Operands and opcode are captured on that edge.
- States:
  - IDLE: in_ready = !out_valid || out_ready.
  - DIV: in_ready = 0.
- From IDLE, an accepted div/mod with in2≠0 goes to DIV. Every other accepted op writes the result register directly and stays in IDLE.
- DIV runs WIDTH iterations (one quotient bit per cycle), then writes the result register and returns to IDLE.
- Result register: an accept on the edge out_valid && out_ready sets out_valid. With no new result on that edge, out_valid clears. A new result and a consume on the same edge keep out_valid at 1.
- Arithmetic width rules:
  - cpy: zero-extend in1.
  - add: full WIDTH+1-bit sum; carry in MSB.
  - sub: (in1−in2) mod 2^(WIDTH+1); MSB=1 means borrow.
  - div: quotient, zero-extended.
  - mod: remainder, zero-extended.
  - shl: ({0,in1} << amt) truncated to WIDTH+1 bits, where amt = in2[SHW-1:0]; amt>WIDTH gives 0.
  - shr: {0,in1} >> amt; amt>WIDTH gives 0.
  - cmp: 1 if in1 > in2 unsigned, else 0.
- Divide by zero: completes in one cycle without entering DIV, with dz=1.
  - div result: all ones (WIDTH+1 bits).
  - mod result: zero-extended in1.
- dz is 0 for every other result.
- in_valid while in_ready=0: the operation is not accepted, and the upstream holds its inputs.
- Reset (async, any state, including mid-DIV): state=IDLE, out_valid=0, out=0, dz=0, divider registers cleared, in_ready=1 once rst is released. Any in-flight divide is discarded.

## Timing
- Non-divide ops and div-by-zero: accepted at edge N; out_valid=1 after edge N (1-cycle latency).
- div/mod with in2≠0: accepted at edge N; DIV occupies edges N+1..N+WIDTH; out_valid=1 after edge N+WIDTH (WIDTH-cycle latency).
- Throughput:
  - One non-divide op per cycle when out_ready is held at 1.
  - Back-to-back divides: one per WIDTH+1 cycles (the DIV→IDLE cycle accepts the next op only if the result slot frees).
- out and dz are stable while out_valid && !out_ready.
- All outputs are registered or decoded from state only. There is no combinational path from in_* to out_*. in_ready depends combinationally on out_ready.

## Structure
- Package seq_alu_pkg:
  - Opcode enum (OP_CPY…OP_CMP, 3-bit).
  - State enum (S_IDLE, S_DIV).
- Sub-module alu_divider:
  - Ports: start, dividend, divisor, busy, done, quotient, remainder.
  - Implements a WIDTH-iteration restoring divider with an internal counter.
  - seq_alu instantiates it once and owns the handshake and result register.

## Test plan
- Reset mid-divide:
  - Stimulus: WIDTH=8; issue div 200/7; assert rst on the 3rd DIV cycle.
  - Response: out_valid=0, out=0, in_ready=1 after release. A following cpy 0x5A yields out=0x05A one cycle after accept.
- Arithmetic sweep:
  - Stimulus: add 0xFF+0x01, sub 0x03−0x05, cmp 9>3, cmp 3>3, each with out_ready=1.
  - Response: 0x100, 0x1FE, 1, 0, each with 1-cycle latency; four ops in four consecutive cycles.
- Divide latency:
  - Stimulus: div 200/7 and mod 200/7.
  - Response: out=28 and 4, each out_valid exactly 8 cycles after accept; dz=0; in_ready=0 throughout DIV.
- Divide by zero:
  - Stimulus: div 0x37/0, then mod 0x37/0.
  - Response: out=0x1FF with dz=1, then out=0x037 with dz=1; each 1-cycle latency.
- Shifts:
  - Stimulus: shl 0x81 by 1, shl 0x81 by 9, shr 0xF0 by 4.
  - Response: 0x102, 0x000, 0x00F.
- Backpressure:
  - Stimulus: out_ready=0, issue add 1+2, then hold in_valid with cpy 0x11.
  - Response: result 3 held stable, in_ready=0, second op not accepted. Raise out_ready: 3 consumed and cpy accepted on the same edge; next cycle out=0x011.
